pipe_hazard_ctrl: RTL

//  Central control for the 5-stage in-order pipeline: drives en/stall/flush on the
//  IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the PC, consuming their
//  ID/EX decode info. Handles run start, load-use interlock, taken-branch flush,

---
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Run/stall/flush control for a 5-stage in-order pipeline.
//            Optional perf counters when PIPE_HAZARD_PERF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_br_taken,
    input  logic              ex_mc_start,
    output logic              pipe_en,
    output logic              pc_stall,
    output logic              pc_redirect,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              running
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_MC_BUSY = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam int             DCW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit             MC_STALLS    = (MC_LAT > 1);
    localparam logic [3:0]     MC_RELOAD    = MC_STALLS ? 4'(MC_LAT - 2) : 4'd0;
    localparam logic [DCW-1:0] DRAIN_RELOAD = DCW'(DEPTH - 1);

    state_t         state, state_d;
    logic [3:0]     mc_cnt, mc_cnt_d;
    logic [DCW-1:0] drain_cnt, drain_cnt_d;
    logic           halt_pend, halt_pend_d;
    logic           load_use, br_go, mc_go;

    assign load_use = ex_valid && ex_is_load && (ex_rd != '0) &&
                      ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));
    assign br_go    = ex_valid && ex_br_taken;
    assign mc_go    = ex_valid && ex_mc_start && MC_STALLS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mc_cnt    <= '0;
            drain_cnt <= '0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_d;
            mc_cnt    <= mc_cnt_d;
            drain_cnt <= drain_cnt_d;
            halt_pend <= halt_pend_d;
        end
    end

    always_comb begin
        state_d     = state;
        mc_cnt_d    = mc_cnt;
        drain_cnt_d = drain_cnt;
        halt_pend_d = halt_pend;
        pipe_en     = 1'b0;
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                pipe_en = 1'b1;
                if (halt || halt_pend) begin
                    pc_stall    = 1'b1;
                    flush_ifid  = 1'b1;
                    halt_pend_d = 1'b0;
                    drain_cnt_d = DRAIN_RELOAD;
                    state_d     = S_DRAIN;
                end else if (br_go) begin
                    // A load-use hit in the same cycle is moot: its ID instr is squashed.
                    pc_redirect = 1'b1;
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                end else if (mc_go) begin
                    pc_stall    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    flush_exmem = 1'b1;
                    mc_cnt_d    = MC_RELOAD;
                    state_d     = S_MC_BUSY;
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            S_MC_BUSY: begin
                pipe_en     = 1'b1;
                pc_stall    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                flush_exmem = 1'b1;
                if (halt) halt_pend_d = 1'b1;
                if (mc_cnt == 4'd0) state_d  = S_RUN;
                else                mc_cnt_d = mc_cnt - 4'd1;
            end
            S_DRAIN: begin
                pipe_en    = 1'b1;
                pc_stall   = 1'b1;
                flush_ifid = 1'b1;
                if (drain_cnt == '0) state_d     = S_IDLE;
                else                 drain_cnt_d = drain_cnt - DCW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign running = (state != S_IDLE);

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall && ((state == S_RUN) || (state == S_MC_BUSY)))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (pc_redirect)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
